cell_pos_fetch: RTL and testbench

- Read sequencer directly upstream of one cell position memory (single-port M20K; registered output; read-only during force evaluation).
- On start, sweeps addresses 0..particle_count-1 and absorbs the memory's fixed read latency.
- Delivers {posz,posy,posx} words with particle id on a valid/ready stream to the force-evaluation pipeline.
- Credit-based issue plus a small output FIFO, so out_ready backpressure never loses a word.

---
 rtl/cell_pos_fetch_pkg.sv | 25 ++
 rtl/cell_pos_fetch_pos_fifo.sv | 71 +++++++
 rtl/cell_pos_fetch.sv | 171 +++++++++++++++++
 tb/tb_cell_pos_fetch.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cell_pos_fetch_pkg.sv
// Shared defaults, fetch FSM encoding and position-word field positions
// for the cell position read sequencer.
package cell_pos_fetch_pkg;

  localparam int DEF_DATA_WIDTH   = 96;
  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int DEF_PARTICLE_NUM = 220;
  localparam int DEF_RD_LATENCY   = 2;
  localparam int DEF_FIFO_DEPTH   = 4;

  localparam int POSX_LSB = 0;
  localparam int POSX_MSB = 31;
  localparam int POSY_LSB = 32;
  localparam int POSY_MSB = 63;
  localparam int POSZ_LSB = 64;
  localparam int POSZ_MSB = 95;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/cell_pos_fetch_pos_fifo.sv
// Show-ahead FIFO holding {last, pid, pos} entries; head is visible while
// not empty, and a full FIFO may be read and written in the same cycle.
module pos_fifo
  import cell_pos_fetch_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH + DEF_ADDR_WIDTH + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    if (do_wr && !do_rd) begin
      count_d = count_q + CW'(1);
    end else if (do_rd && !do_wr) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Upstream credit accounting must make this unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && full && !rd_en));

endmodule

// File: rtl/cell_pos_fetch.sv
// Cell position read sequencer: sweeps the cell memory, absorbs its read
// latency and streams {pos, pid, last} downstream under credit control.
//   state | meaning
//   IDLE  | waiting for start; first read issues with the accepted start
//   FETCH | issuing reads while FIFO credit allows
//   DRAIN | all reads issued, waiting for the last word to be accepted
//   DONE  | one-cycle done pulse
module cell_pos_fetch
  import cell_pos_fetch_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int PARTICLE_NUM = DEF_PARTICLE_NUM,
  parameter int RD_LATENCY   = DEF_RD_LATENCY,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);

  localparam int CNTW = ADDR_WIDTH + 1;
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);
  localparam int OCW  = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;
  localparam int FW   = DATA_WIDTH + ADDR_WIDTH + 1;

  fetch_state_e          state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d, rd_ptr_q, rd_ptr_d;
  logic                  mem_rden_q, mem_rden_d, mem_last_q, mem_last_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d, pipe_last_q, pipe_last_d;
  logic [ADDR_WIDTH-1:0] pipe_pid_q [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] pipe_pid_d [RD_LATENCY];

  logic                  issue, issue_last;
  logic [CNTW-1:0]       issue_addr, cnt_clamp;
  logic [OCW-1:0]        inflight, occupancy;
  logic                  credit_ok, pop, fifo_empty, head_last;
  logic [FCW-1:0]        fifo_count;
  logic [FW-1:0]         fifo_head;

  pos_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pipe_vld_q[RD_LATENCY-1]),
    .wr_data ({pipe_last_q[RD_LATENCY-1], pipe_pid_q[RD_LATENCY-1], mem_q}),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid                    = !fifo_empty;
  assign pop                          = out_valid && out_ready;
  assign {head_last, out_pid, out_pos} = fifo_head;
  assign out_last                     = out_valid && head_last;
  assign mem_address                  = mem_address_q;
  assign mem_rden                     = mem_rden_q;
  assign mem_wren                     = 1'b0;

  // A word popped this cycle frees its slot in time for a read issued now.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + OCW'(pipe_vld_q[i]);
    occupancy = OCW'(fifo_count) + inflight + OCW'(mem_rden_q) - OCW'(pop);
    credit_ok = (occupancy < OCW'(FIFO_DEPTH));
    cnt_clamp = ({1'b0, particle_count} > CNTW'(PARTICLE_NUM)) ?
                CNTW'(PARTICLE_NUM) : {1'b0, particle_count};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    issue      = 1'b0;
    issue_addr = '0;
    issue_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d = cnt_clamp;
          if (cnt_clamp == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_FETCH;
            issue      = 1'b1;
            issue_last = (cnt_clamp == CNTW'(1));
            rd_ptr_d   = CNTW'(1);
          end
        end
      end
      ST_FETCH: begin
        if ((rd_ptr_q < cnt_q) && credit_ok) begin
          issue      = 1'b1;
          issue_addr = rd_ptr_q;
          issue_last = (rd_ptr_q + CNTW'(1) == cnt_q);
          rd_ptr_d   = rd_ptr_q + CNTW'(1);
        end
        if (rd_ptr_d == cnt_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && head_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    mem_rden_d    = issue;
    mem_address_d = issue ? issue_addr[ADDR_WIDTH-1:0] : mem_address_q;
    mem_last_d    = issue && issue_last;

    pipe_vld_d[0]  = mem_rden_q;
    pipe_last_d[0] = mem_last_q;
    pipe_pid_d[0]  = mem_address_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
      pipe_pid_d[i]  = pipe_pid_q[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_FETCH, ST_DRAIN: busy = 1'b1;
      ST_DONE:            done = 1'b1;
      default:            ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rd_ptr_q      <= '0;
      mem_rden_q    <= 1'b0;
      mem_last_q    <= 1'b0;
      mem_address_q <= '0;
      pipe_vld_q    <= '0;
      pipe_last_q   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_pid_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_rden_q    <= mem_rden_d;
      mem_last_q    <= mem_last_d;
      mem_address_q <= mem_address_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_last_q   <= pipe_last_d;
      pipe_pid_q    <= pipe_pid_d;
    end
  end

endmodule

// File: tb/tb_cell_pos_fetch.sv
// Directed bench for cell_pos_fetch with a two-cycle registered memory model
// and an in-order expectation of pid/position on every output cycle.
module tb_cell_pos_fetch;

  localparam int DW    = 96;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          clk, rst_n, start, busy, done, mem_rden, mem_wren;
  logic [AW-1:0] particle_count, mem_address, out_pid;
  logic [DW-1:0] mem_q, mem_stage, out_pos;
  logic          out_valid, out_ready, out_last;

  int checks = 0;
  int errors = 0;

  cell_pos_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .particle_count (particle_count),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_rden       (mem_rden),
    .mem_wren       (mem_wren),
    .mem_q          (mem_q),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pos        (out_pos),
    .out_pid        (out_pid),
    .out_last       (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pos_of(input logic [AW-1:0] a);
    pos_of = {32'hC0DE0000 + 32'(a) * 32'd7, 32'h5A000000 | 32'(a), 32'h00010000 + 32'(a)};
  endfunction

  // Memory model: registered address stage plus registered output.
  always @(posedge clk) begin
    mem_stage <= mem_rden ? pos_of(mem_address) : {3{32'hBAD0BAD0}};
    mem_q     <= mem_stage;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},     128'(busy),        128'(0));
    chk({tag, "_done"},     128'(done),        128'(0));
    chk({tag, "_rden"},     128'(mem_rden),    128'(0));
    chk({tag, "_wren"},     128'(mem_wren),    128'(0));
    chk({tag, "_addr"},     128'(mem_address), 128'(0));
    chk({tag, "_valid"},    128'(out_valid),   128'(0));
    chk({tag, "_last"},     128'(out_last),    128'(0));
    chk({tag, "_pos"},      128'(out_pos),     128'(0));
    chk({tag, "_pid"},      128'(out_pid),     128'(0));
  endtask

  // Call with start=1 already driven; the next rising edge is edge 0.
  task automatic run_stream(input string tag, input int exp_cnt, input int stall_after,
                            input int stall_len, input int repulse_cyc, input int exp_done_cyc);
    int cyc = 0, acc = 0, issued = 0, stall_left = 0;
    bit stalled = 0, seen_valid = 0, expect_done = 0, fin = 0;
    while (!fin && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == repulse_cyc);
      if (cyc == repulse_cyc) particle_count = 8'd3;
      if (expect_done) begin
        chk({tag, "_done"}, 128'(done), 128'(1));
        chk({tag, "_busy_at_done"}, 128'(busy), 128'(0));
        if (exp_done_cyc > 0) chk({tag, "_done_cycle"}, 128'(cyc), 128'(exp_done_cyc));
        fin = 1;
      end else begin
        if (stall_len > 0 && !stalled && acc == stall_after) begin
          stalled    = 1;
          stall_left = stall_len;
        end
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        chk({tag, "_busy"}, 128'(busy), 128'(1));
        chk({tag, "_no_done"}, 128'(done), 128'(0));
        if (cyc == 1) begin
          chk({tag, "_first_rden"}, 128'(mem_rden), 128'(1));
          chk({tag, "_first_addr"}, 128'(mem_address), 128'(0));
        end
        if (mem_rden) begin
          issued++;
          chk({tag, "_addr_range"}, 128'(int'(mem_address) < exp_cnt), 128'(1));
        end
        chk({tag, "_outstanding"}, 128'((issued - acc) <= DEPTH), 128'(1));
        if (out_valid) begin
          if (!seen_valid) begin
            seen_valid = 1;
            chk({tag, "_first_valid_cycle"}, 128'(cyc), 128'(4));
          end
          chk({tag, "_pid"}, 128'(out_pid), 128'(acc));
          chk({tag, "_pos"}, 128'(out_pos), 128'(pos_of(8'(acc))));
          chk({tag, "_last"}, 128'(out_last), 128'(acc == exp_cnt - 1));
          if (out_ready) begin
            acc++;
            if (acc == exp_cnt) expect_done = 1;
          end
        end
      end
    end
    chk({tag, "_word_count"}, 128'(acc), 128'(exp_cnt));
    chk({tag, "_completed"}, 128'(fin), 128'(1));
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 128'(done), 128'(0));
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    particle_count = '0;
    out_ready      = 1'b1;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Five particles, no backpressure: valid cycles 4..8, done at 9.
    particle_count = 8'd5;
    start          = 1'b1;
    run_stream("p5", 5, -1, 0, 0, 9);

    // Twenty particles with a ten-cycle stall after two accepts.
    particle_count = 8'd20;
    start          = 1'b1;
    run_stream("p20_stall", 20, 2, 10, 0, 0);

    // Empty cell: done in cycle 1, no reads, no output.
    particle_count = 8'd0;
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("p0_done", 128'(done), 128'(1));
    chk("p0_busy", 128'(busy), 128'(0));
    chk("p0_rden", 128'(mem_rden), 128'(0));
    chk("p0_valid", 128'(out_valid), 128'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("p0_after_done", 128'(done), 128'(0));
      chk("p0_after_rden", 128'(mem_rden), 128'(0));
      chk("p0_after_valid", 128'(out_valid), 128'(0));
    end

    // Oversized request clamps to 220 words.
    particle_count = 8'd250;
    start          = 1'b1;
    run_stream("p250", 220, -1, 0, 0, 224);

    // Reset in cycle 6 of a 10-particle sweep; late read data must vanish.
    particle_count = 8'd10;
    start          = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_quiet("midreset");
    rst_n = 1'b1;
    for (int c = 8; c <= 10; c++) begin
      @(negedge clk);
      chk("midreset_late_valid", 128'(out_valid), 128'(0));
      chk("midreset_late_rden", 128'(mem_rden), 128'(0));
    end
    particle_count = 8'd10;
    start          = 1'b1;
    run_stream("p10_after_reset", 10, -1, 0, 0, 14);

    // Start re-pulsed with a new count during FETCH: ignored.
    particle_count = 8'd7;
    start          = 1'b1;
    run_stream("p7_repulse", 7, -1, 0, 3, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
